// File: rtl/wb_arbiter.sv
// wb_arbiter - register-file write-port arbiter between the pipeline WB stage
// and a 2-entry buffer of multicycle results, with starvation-driven stall.
module wb_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pipe_vld,
  input  logic [4:0]  i_pipe_rd,
  input  logic [31:0] i_pipe_data,
  input  logic        i_mc_vld,
  output logic        o_mc_rdy,
  input  logic [4:0]  i_mc_rd,
  input  logic [31:0] i_mc_data,
  output logic        o_rf_wren,
  output logic [4:0]  o_rf_rd,
  output logic [31:0] o_rf_data,
  output logic        o_stall,
  output logic [1:0]  o_fifo_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [4:0]  fifo_rd_q   [2];
  logic [31:0] fifo_data_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        rf_wren_q, rf_wren_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_data_q, rf_data_d;

  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        pipe_req;

  assign fifo_empty = (cnt_q == 2'd0);
  assign o_mc_rdy   = (cnt_q != 2'd2);
  assign o_stall    = (starve_q == STARVE_LIM) && !fifo_empty;
  assign o_fifo_cnt = cnt_q;
  assign o_rf_wren  = rf_wren_q;
  assign o_rf_rd    = rf_rd_q;
  assign o_rf_data  = rf_data_q;

  // Writes to x0 are meaningless, so they never reach the buffer or the port.
  assign push     = i_mc_vld && o_mc_rdy && (i_mc_rd != 5'd0);
  assign pipe_req = i_pipe_vld && (i_pipe_rd != 5'd0);

  always_comb begin
    pop       = 1'b0;
    rf_wren_d = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_data_d = rf_data_q;
    if (o_stall || (!pipe_req && !fifo_empty)) begin
      pop       = 1'b1;
      rf_wren_d = 1'b1;
      rf_rd_d   = fifo_rd_q[rd_ptr_q];
      rf_data_d = fifo_data_q[rd_ptr_q];
    end else if (pipe_req) begin
      rf_wren_d = 1'b1;
      rf_rd_d   = i_pipe_rd;
      rf_data_d = i_pipe_data;
    end
  end

  always_comb begin
    wr_ptr_d = push ? !wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? !rd_ptr_q : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 2'd1;
    end
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = 4'd0;
    end else if (starve_q != STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      starve_q  <= 4'd0;
      rf_wren_q <= 1'b0;
      rf_rd_q   <= 5'd0;
      rf_data_q <= 32'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      rf_wren_q <= rf_wren_d;
      rf_rd_q   <= rf_rd_d;
      rf_data_q <= rf_data_d;
    end
  end

  // Buffer storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= i_mc_rd;
      fifo_data_q[wr_ptr_q] <= i_mc_data;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter against a queue-based model.
module tb_wb_arbiter;

  localparam int SM = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_pipe_vld = 1'b0;
  logic [4:0]  i_pipe_rd = '0;
  logic [31:0] i_pipe_data = '0;
  logic        i_mc_vld = 1'b0;
  logic        o_mc_rdy;
  logic [4:0]  i_mc_rd = '0;
  logic [31:0] i_mc_data = '0;
  logic        o_rf_wren;
  logic [4:0]  o_rf_rd;
  logic [31:0] o_rf_data;
  logic        o_stall;
  logic [1:0]  o_fifo_cnt;

  wb_arbiter #(.STARVE_MAX(SM)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_pipe_vld(i_pipe_vld), .i_pipe_rd(i_pipe_rd), .i_pipe_data(i_pipe_data),
    .i_mc_vld(i_mc_vld), .o_mc_rdy(o_mc_rdy), .i_mc_rd(i_mc_rd), .i_mc_data(i_mc_data),
    .o_rf_wren(o_rf_wren), .o_rf_rd(o_rf_rd), .o_rf_data(o_rf_data),
    .o_stall(o_stall), .o_fifo_cnt(o_fifo_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  typedef struct { logic wren; logic [4:0] rd; logic [31:0] data; } exp_t;

  ent_t        mq[$];
  exp_t        sb[$];
  int          starve = 0;
  logic [4:0]  last_rd = '0;
  logic [31:0] last_data = '0;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb.delete();
    starve    = 0;
    last_rd   = '0;
    last_data = '0;
  endtask

  // One cycle, entered at a falling edge; returns after the next falling edge.
  task automatic step(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                      output bit accepted, output bit stall_seen);
    exp_t e;
    ent_t n;
    int   size_pre;
    bit   stall_e;
    bit   popped;
    size_pre = mq.size();
    stall_e  = (starve == SM) && (size_pre > 0);
    chk("stall", o_stall, stall_e);
    chk("fifo_cnt", o_fifo_cnt, size_pre);
    chk("mc_rdy", o_mc_rdy, size_pre < 2);
    i_pipe_vld = pv; i_pipe_rd = prd; i_pipe_data = pdata;
    i_mc_vld = mv; i_mc_rd = mrd; i_mc_data = mdata;
    e.wren = 1'b0; e.rd = last_rd; e.data = last_data;
    popped = 0;
    if (stall_e || (!(pv && prd != 0) && size_pre > 0)) begin
      n = mq.pop_front();
      e.wren = 1'b1; e.rd = n.rd; e.data = n.data;
      popped = 1;
    end else if (pv && prd != 0) begin
      e.wren = 1'b1; e.rd = prd; e.data = pdata;
    end
    accepted = mv && (size_pre < 2);
    if (accepted && mrd != 0) begin
      n.rd = mrd; n.data = mdata;
      mq.push_back(n);
    end
    if (size_pre == 0 || popped) starve = 0;
    else if (starve < SM) starve++;
    last_rd = e.rd; last_data = e.data;
    sb.push_back(e);
    stall_seen = stall_e;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rf_wren", o_rf_wren, e.wren);
        chk("rf_rd", o_rf_rd, e.rd);
        chk("rf_data", o_rf_data, e.data);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit          acc, st;
    int          cyc;
    logic        pv, mv;
    logic [4:0]  prd, mrd;
    logic [31:0] pd, md;
    bit          hold_mc;

    #2;
    chk("rst_wren", o_rf_wren, 0);
    chk("rst_rd", o_rf_rd, 0);
    chk("rst_data", o_rf_data, 0);
    chk("rst_cnt", o_fifo_cnt, 0);
    chk("rst_rdy", o_mc_rdy, 1);
    chk("rst_stall", o_stall, 0);
    @(negedge i_clk); @(negedge i_clk);
    i_rst_n = 1'b1;

    // Pipeline-only write.
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, acc, st);
    step(0, 0, 0, 0, 0, 0, acc, st);

    // Idle-pipe drain of one buffered result.
    step(0, 0, 0, 1, 5'd7, 32'h11, acc, st);
    step(0, 0, 0, 0, 0, 0, acc, st);
    step(0, 0, 0, 0, 0, 0, acc, st);

    // Starvation under a continuously busy pipeline.
    step(0, 0, 0, 1, 5'd9, 32'h99, acc, st);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      if (cyc == 0 && o_stall) cyc = i;
      step(1, 5'd3, 32'h3000 + i, 0, 0, 0, acc, st);
    end
    chk("stall_cycle", cyc, 5);

    // Fill the buffer; third offer held until accepted.
    step(1, 5'd4, 32'hA0, 1, 5'd1, 32'h1, acc, st);
    step(1, 5'd4, 32'hA1, 1, 5'd2, 32'h2, acc, st);
    chk("full_cnt", o_fifo_cnt, 2);
    chk("full_rdy", o_mc_rdy, 0);
    acc = 0;
    for (int i = 0; i < 20 && !acc; i++)
      step(1, 5'd4, 32'hB0 + i, 1, 5'd3, 32'h3, acc, st);
    chk("third_accepted", acc, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, acc, st);

    // x0 destinations are filtered on both sides.
    for (int i = 0; i < 4; i++) step(1, 5'd0, 32'h55, 1, 5'd0, 32'h66, acc, st);
    chk("x0_cnt", o_fifo_cnt, 0);

    // Asynchronous reset with a full buffer.
    step(1, 5'd6, 32'hC0, 1, 5'd10, 32'hE1, acc, st);
    step(1, 5'd6, 32'hC1, 1, 5'd11, 32'hE2, acc, st);
    chk("pre_rst_cnt", o_fifo_cnt, 2);
    i_pipe_vld = 0; i_mc_vld = 0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_wren", o_rf_wren, 0);
    chk("arst_rd", o_rf_rd, 0);
    chk("arst_data", o_rf_data, 0);
    chk("arst_cnt", o_fifo_cnt, 0);
    chk("arst_rdy", o_mc_rdy, 1);
    chk("arst_stall", o_stall, 0);
    model_reset();
    @(negedge i_clk); @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, acc, st);

    // Randomized traffic.
    hold_mc = 0; st = 0;
    pv = 0; prd = 0; pd = 0; mv = 0; mrd = 0; md = 0;
    for (int i = 0; i < 600; i++) begin
      if (!st) begin
        pv  = ($urandom_range(0, 9) < 7);
        prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        pd  = $urandom;
      end
      if (!hold_mc) begin
        mv  = ($urandom_range(0, 2) == 0);
        mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        md  = $urandom;
      end
      step(pv, prd, pd, mv, mrd, md, acc, st);
      hold_mc = mv && !acc;
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, acc, st);
    @(posedge i_clk); #2;
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, is the number of consecutive cycles the buffered multicycle result may be denied before the pipeline is stalled (legal range 1..15).
REQ-002 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-004 i_pipe_vld  in  1  pipeline WB stage requests a register-file write this cycle.
REQ-005 i_pipe_rd  in  5  destination register of the pipeline write.
REQ-006 i_pipe_data  in  32  write data from the WB mux.
REQ-007 i_mc_vld  in  1  multicycle unit (mul/div/load-miss) offers a result.
REQ-008 o_mc_rdy  out  1  arbiter can accept a multicycle result; handshake completes when i_mc_vld & o_mc_rdy.
REQ-009 i_mc_rd  in  5  destination register of the multicycle result.
REQ-010 i_mc_data  in  32  multicycle result data.
REQ-011 o_rf_wren  out  1  registered register-file write enable.
REQ-012 o_rf_rd  out  5  registered write address.
REQ-013 o_rf_data  out  32  registered write data.
REQ-014 o_stall  out  1  pipeline must hold its WB stage this cycle.
REQ-015 o_fifo_cnt  out  2  current multicycle buffer occupancy (0..2).

Function
REQ-016 Multicycle results SHALL be buffered in a 2-entry FIFO; o_mc_rdy = (o_fifo_cnt != 2), derived from registered state only.
REQ-017 A handshaken multicycle result with i_mc_rd = 0 SHALL be discarded, not enqueued.
REQ-018 A pipeline request with i_pipe_rd = 0 SHALL be treated as no request.
REQ-019 Grant per cycle: o_stall=1 -> FIFO head; else valid pipeline request -> pipeline; else FIFO non-empty -> FIFO head; else none.
REQ-020 When o_stall=1 the arbiter SHALL ignore i_pipe_vld; the pipeline re-presents the same write next cycle.
REQ-021 The granted write SHALL appear on o_rf_wren/o_rf_rd/o_rf_data on the next rising edge (latency 1); no grant -> o_rf_wren=0, o_rf_rd/o_rf_data hold their previous values.
REQ-022 A FIFO-head grant SHALL pop the head in the same edge; push and pop in one cycle SHALL leave o_fifo_cnt unchanged and preserve order.
REQ-023 Starvation counter (4 bits): increments when FIFO non-empty and head not granted; clears on a FIFO-head grant or when FIFO empty; saturates at STARVE_MAX.
REQ-024 o_stall = (starvation counter == STARVE_MAX) and FIFO non-empty; combinational from registered state; asserted for exactly one cycle per starvation event.
REQ-025 FIFO order SHALL be strict arrival order; no entry is dropped or duplicated.
REQ-026 No combinational path SHALL exist from i_mc_vld to o_mc_rdy or from any input to o_stall.

Reset
REQ-027 While i_rst_n=0: o_rf_wren=0, o_rf_rd=0, o_rf_data=0, o_fifo_cnt=0, o_mc_rdy=1, o_stall=0, starvation counter=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries immediately; no write issues on the first edge after release unless requested that cycle.

Verification
REQ-029 Pipe only: i_pipe_vld=1, rd=5, data=0xDEADBEEF -> next cycle o_rf_wren=1, o_rf_rd=5, o_rf_data=0xDEADBEEF.
REQ-030 Idle-pipe drain: push mc rd=7 data=0x11, pipe idle -> one cycle later o_rf_wren=1, rd=7, data=0x11; o_fifo_cnt back to 0.
REQ-031 Starvation: one mc entry, i_pipe_vld=1 continuously, STARVE_MAX=4 -> o_stall=1 on the 5th cycle after enqueue, mc entry written next edge, pipe writes resume the following cycle.
REQ-032 Full: two mc pushes with pipe busy -> o_fifo_cnt=2, o_mc_rdy=0; third i_mc_vld held until a pop, then accepted; write order 1,2,3.
REQ-033 x0 filter: pipe rd=0 and mc rd=0 -> o_rf_wren never asserted, o_fifo_cnt stays 0.
REQ-034 Reset mid-operation: o_fifo_cnt=2, drive i_rst_n=0 asynchronously between edges -> outputs per REQ-027 immediately; neither buffered entry is ever written.
